key_debounce_multi: RTL and testbench

- Multi-channel push-button/switch debouncer with edge-event and long-press outputs.
- One shared tick prescaler drives CH independent per-channel debounce FSMs.
- Each channel gives a clean level, one-cycle press and release pulses, and a one-shot long-press pulse.
- Sits between raw board inputs and game/control logic. Replaces single-key debouncers wherever more than one key is used.

---
 rtl/key_pkg.sv | 32 +++
 rtl/key_debounce_ch.sv | 161 ++++++++++++++++
 rtl/key_debounce_multi.sv | 71 +++++++
 tb/tb_key_debounce_multi.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : key_pkg                                                        |
// | Purpose : Shared types and helpers for the multi-channel key debouncer.  |
// |           Defines the per-channel debounce state encoding and a          |
// |           constant-evaluable ceil(log2()) used to size counters.         |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package key_pkg;

  // ZERO/ONE are the settled levels.
  // WAIT1/WAIT0 are candidate transitions that are still being qualified.
  typedef enum logic [1:0] {
    ST_ZERO  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_ONE   = 2'd2,
    ST_WAIT0 = 2'd3
  } key_state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : key_debounce_ch                                                |
// | Purpose : One debounce channel. It has an input synchroniser, a          |
// |           four-state qualify FSM counted in prescaler ticks, and an      |
// |           optional long-press hold counter. All outputs are registered.  |
// | Ports   : clk        - system clock                                      |
// |           reset      - asynchronous active-high reset                    |
// |           sw_i       - raw asynchronous key input (1 = pressed)          |
// |           tick_i     - shared one-cycle debounce tick                    |
// |           level_o    - debounced level                                   |
// |           press_o    - one-cycle pulse on accepted 0->1                  |
// |           release_o  - one-cycle pulse on accepted 1->0                  |
// |           long_o     - one-cycle pulse once per press after long hold    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int N_STABLE    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_TICKS  = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  input  logic tick_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int             CW       = clog2(N_STABLE + 1);
  localparam logic [CW-1:0]  CNT_DONE = CW'(N_STABLE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  key_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, press_q, release_q;

  // Input synchroniser: the oldest stage is the qualified sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A reversal of s is checked before the tick.
  // This lets a reversal in the same cycle as a tick win, and no count is taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ZERO: begin
        if (s) begin
          state_d = ST_WAIT1;
          cnt_d   = '0;
        end
      end
      ST_WAIT1: begin
        if (!s) begin
          state_d = ST_ZERO;
        end else if (tick_i) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CNT_DONE) begin
            state_d = ST_ONE;
          end
        end
      end
      ST_ONE: begin
        if (!s) begin
          state_d = ST_WAIT0;
          cnt_d   = '0;
        end
      end
      ST_WAIT0: begin
        if (s) begin
          state_d = ST_ONE;
        end else if (tick_i) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CNT_DONE) begin
            state_d = ST_ZERO;
          end
        end
      end
      default: begin
        state_d = ST_ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  // The outputs are decoded from the next state.
  // This way they change in the same cycle as the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ZERO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= (state_d == ST_ONE) || (state_d == ST_WAIT0);
      press_q   <= (state_q == ST_WAIT1) && (state_d == ST_ONE);
      release_q <= (state_q == ST_WAIT0) && (state_d == ST_ZERO);
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

  if (LONG_TICKS > 0) begin : g_long
    localparam int            HW        = clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] HOLD_DONE = HW'(LONG_TICKS);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_q, long_d;

    // The hold counter saturates at HOLD_DONE.
    // Because of this the pulse can only fire once per press.
    // A bounce that goes WAIT0->ONE keeps the hold count.
    always_comb begin
      hcnt_d = hcnt_q;
      long_d = 1'b0;
      if (state_d == ST_ZERO) begin
        hcnt_d = '0;
      end else if ((state_q == ST_WAIT1) && (state_d == ST_ONE)) begin
        hcnt_d = '0;
      end else if (tick_i && ((state_q == ST_ONE) || (state_q == ST_WAIT0)) &&
                   (hcnt_q != HOLD_DONE)) begin
        hcnt_d = hcnt_q + HW'(1);
        long_d = (hcnt_d == HOLD_DONE);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hcnt_q <= '0;
        long_q <= 1'b0;
      end else begin
        hcnt_q <= hcnt_d;
        long_q <= long_d;
      end
    end

    assign long_o = long_q;
  end else begin : g_no_long
    assign long_o = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/key_debounce_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : key_debounce_multi                                             |
// | Purpose : Multi-channel key debouncer. One shared tick prescaler feeds   |
// |           CH independent debounce channels.                              |
// | Ports   : clk          - system clock                                    |
// |           reset        - asynchronous active-high reset                  |
// |           sw[CH]       - raw key inputs, 1 = pressed                     |
// |           key_level    - debounced level per channel                     |
// |           key_press    - one-cycle pulse per accepted press              |
// |           key_release  - one-cycle pulse per accepted release            |
// |           key_long     - one-cycle long-press pulse, once per press      |
// |           tick         - prescaler tick (debug / reuse)                  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int CH          = 4,
  parameter int TICK_DIV    = 1048576,
  parameter int N_STABLE    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_TICKS  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] key_level,
  output logic [CH-1:0] key_press,
  output logic [CH-1:0] key_release,
  output logic [CH-1:0] key_long,
  output logic          tick
);

  localparam int            PW       = clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;

  // The tick is decoded from the count register.
  // While the count is 0 in reset, the tick is low.
  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    key_debounce_ch #(
      .N_STABLE    (N_STABLE),
      .SYNC_STAGES (SYNC_STAGES),
      .LONG_TICKS  (LONG_TICKS)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sw_i      (sw[i]),
      .tick_i    (tick),
      .level_o   (key_level[i]),
      .press_o   (key_press[i]),
      .release_o (key_release[i]),
      .long_o    (key_long[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_key_debounce_multi                                          |
// | Purpose : Self-checking bench for key_debounce_multi (CH=2, TICK_DIV=4,  |
// |           N_STABLE=3, SYNC_STAGES=2, LONG_TICKS=5).                      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_key_debounce_multi;

  localparam int CH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] sw;
  logic [CH-1:0] key_level, key_press, key_release, key_long;
  logic          tick;

  key_debounce_multi #(
    .CH          (CH),
    .TICK_DIV    (4),
    .N_STABLE    (3),
    .SYNC_STAGES (2),
    .LONG_TICKS  (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw          (sw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pulse counters accumulated over a stimulus window.
  int np[CH];
  int nr[CH];
  int nl[CH];

  typedef struct {
    string       name;
    logic [1:0]  sw;
    int          cycles;
    int          p0, p1, r0, r1, l0, l1;
    logic [1:0]  lvl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) begin
      np[c] = 0;
      nr[c] = 0;
      nl[c] = 0;
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        np[c] += int'(key_press[c]);
        nr[c] += int'(key_release[c]);
        nl[c] += int'(key_long[c]);
      end
    end
  endtask

  function automatic void add(input string n, input logic [1:0] s, input int cyc,
                              input int p0, input int p1, input int r0, input int r1,
                              input int l0, input int l1, input logic [1:0] lvl);
    vec_t v;
    v.name = n; v.sw = s; v.cycles = cyc;
    v.p0 = p0; v.p1 = p1; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
    v.lvl = lvl;
    vecs.push_back(v);
  endfunction

  // Wait until tick is seen high in a sample (bounded).
  // The next rising edge is then a tick edge.
  task automatic align_tick(output bit found);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(posedge clk);
      #1;
      if (tick) found = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int   lat;
    bit   found;
    vec_t e;

    // ---------------- reset state ----------------
    reset = 1'b1;
    sw    = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {key_level, key_press, key_release, key_long, tick}, 0);

    // ---------------- first tick and tick period ----------------
    reset = 1'b0;
    lat   = 0;
    for (int i = 0; i < 20 && !tick; i++) begin
      @(posedge clk);
      #1;
      lat++;
    end
    // The count reaches TICK_DIV-1 after three edges.
    // The tick is consumed at the fourth edge.
    check("first_tick_edges", lat, 3);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (tick) break;
    end
    check("tick_period", lat, 4);

    // ---------------- clean press latency ----------------
    // Latency counts edges, including the one that first samples sw.
    // Expect 2 sync stages, +1 edge into WAIT1, then 3 ticks that take 9..12 edges.
    sw = 2'b01;
    lat = 0;
    clear_counts();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      lat++;
      np[1] += int'(key_press[1] | key_level[1] | key_release[1] | key_long[1]);
      if (key_press[0]) break;
    end
    check("press_latency_in_range", (lat >= 12 && lat <= 15), 1);
    check("press_level_now", key_level, 2'b01);
    check("ch1_quiet_during_press", np[1], 0);
    run_cycles(30);
    sw = 2'b00;
    run_cycles(30);
    check("initial_release_level", key_level, 2'b00);

    // ---------------- table-driven vectors ----------------
    add("press0",      2'b01, 40, 1, 0, 0, 0, 1, 0, 2'b01);
    add("rel0",        2'b00, 30, 0, 0, 1, 0, 0, 0, 2'b00);
    for (int k = 0; k < 10; k++) begin
      add($sformatf("bounce%0d", k), (k % 2 == 0) ? 2'b01 : 2'b00, 3, 0, 0, 0, 0, 0, 0, 2'b00);
    end
    add("bounce_hold", 2'b01, 40, 1, 0, 0, 0, 1, 0, 2'b01);
    add("glitch_lo",   2'b00,  5, 0, 0, 0, 0, 0, 0, 2'b01);
    add("glitch_hi",   2'b01,  2, 0, 0, 0, 0, 0, 0, 2'b01);
    add("glitch_rel",  2'b00, 30, 0, 0, 1, 0, 0, 0, 2'b00);
    add("long1",       2'b10, 60, 0, 1, 0, 0, 0, 1, 2'b10);
    add("rel1",        2'b00, 30, 0, 0, 0, 1, 0, 0, 2'b00);
    add("long1b",      2'b10, 60, 0, 1, 0, 0, 0, 1, 2'b10);
    add("rel1b",       2'b00, 30, 0, 0, 0, 1, 0, 0, 2'b00);
    add("both",        2'b11, 40, 1, 1, 0, 0, 1, 1, 2'b11);
    add("both_rel",    2'b00, 30, 0, 0, 1, 1, 0, 0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      sw = vecs[i].sw;
      sb.push_back(vecs[i]);
      clear_counts();
      run_cycles(vecs[i].cycles);
      e = sb.pop_front();
      check({e.name, "_press"},   {np[1][15:0], np[0][15:0]}, {e.p1[15:0], e.p0[15:0]});
      check({e.name, "_release"}, {nr[1][15:0], nr[0][15:0]}, {e.r1[15:0], e.r0[15:0]});
      check({e.name, "_long"},    {nl[1][15:0], nl[0][15:0]}, {e.l1[15:0], e.l0[15:0]});
      check({e.name, "_level"},   key_level, e.lvl);
    end

    // ---------------- reset mid-operation ----------------
    sw = 2'b10;
    run_cycles(40);            // channel 1 settles in ONE
    sw = 2'b11;
    run_cycles(4);             // channel 0 is in WAIT1 and not yet accepted
    check("pre_reset_level", key_level, 2'b10);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {key_level, key_press, key_release, key_long, tick}, 0);
    clear_counts();
    run_cycles(2);
    check("reset_no_release", nr[0] + nr[1] + np[0] + np[1], 0);
    reset = 1'b0;
    clear_counts();
    run_cycles(20);
    check("post_reset_press", {np[1][15:0], np[0][15:0]}, {16'd1, 16'd1});
    check("post_reset_no_release", nr[0] + nr[1], 0);
    sw = 2'b00;
    run_cycles(30);

    // ---------------- tick / reversal collision ----------------
    // Control case: s drops one cycle after the third tick edge, so the press is accepted.
    align_tick(found);
    check("align_ctrl_found", found, 1'b1);
    sw[0] = 1'b1;
    clear_counts();
    run_cycles(11);
    sw[0] = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (key_press[0]) break;
    end
    check("collision_ctrl_press_edge", lat, 2);
    run_cycles(30);

    // Collision: s drops in exactly the cycle of the third tick (cnt=2), so no press.
    align_tick(found);
    check("align_coll_found", found, 1'b1);
    sw[0] = 1'b1;
    clear_counts();
    run_cycles(10);
    sw[0] = 1'b0;
    run_cycles(20);
    check("collision_no_press", np[0], 0);
    check("collision_level", key_level[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
